// File: rtl/l2_mem_responder.sv
// l2_mem_responder: L2 stand-in behind the I/D arbiter. Accepts one level-held
// read or write at a time, services it from an internal word-addressed memory
// after LATENCY cycles and reports completion with a one-cycle resp pulse.
// Optional feature macro: L2_RESP_ZERO_INIT_EN (zero the memory after reset).
//
// state | meaning
// ------+---------------------------------------------------------------
// CLEAR | zeroing one word per cycle after reset (macro builds only)
// IDLE  | waiting for read/write; request latched on the accepting edge
// BUSY  | counting down the remaining wait cycles; inputs ignored
// RESP  | resp pulse cycle; rdata valid
// TURN  | one dead cycle that swallows the request still visible after resp
module l2_mem_responder #(
  parameter int width     = 32,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 L2cache_read,
  input  logic                 L2cache_write,
  input  logic [31:0]          L2cache_address,
  input  logic [width-1:0]     L2cache_wdata,
  input  logic [3:0]           L2cache_byte_enable,
  output logic [width-1:0]     L2cache_rdata,
  output logic                 L2cache_resp
);

`ifdef L2_RESP_ZERO_INIT_EN
  typedef enum logic [2:0] {IDLE, BUSY, RESP, TURN, CLEAR} state_t;
  localparam state_t RESET_STATE = CLEAR;
`else
  typedef enum logic [1:0] {IDLE, BUSY, RESP, TURN} state_t;
  localparam state_t RESET_STATE = IDLE;
`endif

  localparam int DEPTH = 2 ** ADDR_BITS;

  state_t                 state;
  logic [7:0]             cnt;
  logic                   op_wr;
  logic [ADDR_BITS-1:0]   idx;
  logic [width-1:0]       wdata_q;
  logic [3:0]             be_q;

  logic [width-1:0]       mem [DEPTH];

  logic                   req;
  logic                   acc;
  logic                   go_resp;
  logic                   cur_wr;
  logic [ADDR_BITS-1:0]   cur_idx;
  logic [width-1:0]       cur_wdata;
  logic [3:0]             cur_be;
  logic [width-1:0]       rd_word;
  logic [width-1:0]       merged;
  logic                   mem_we;

`ifdef L2_RESP_ZERO_INIT_EN
  logic [ADDR_BITS-1:0]   clr_idx;
  logic                   clr_we;
`endif

  // Address bits outside the word index are deliberately ignored (aliasing).
  logic unused_addr;
  assign unused_addr = ^{L2cache_address[31:ADDR_BITS+2], L2cache_address[1:0]};

  assign req = L2cache_read | L2cache_write;
  assign acc = (state == IDLE) && req;

  // With LATENCY=1 the accepting edge is also the RESP-entry edge, so the
  // datapath takes the live inputs in IDLE and the latched copy otherwise.
  always_comb begin
    go_resp   = ((LATENCY == 1) && acc) || ((state == BUSY) && (cnt == 8'd1));
    cur_wr    = acc ? L2cache_write                       : op_wr;
    cur_idx   = acc ? L2cache_address[ADDR_BITS+1:2]      : idx;
    cur_wdata = acc ? L2cache_wdata                       : wdata_q;
    cur_be    = acc ? L2cache_byte_enable                 : be_q;
  end

  assign rd_word = mem[cur_idx];

  // Byte-lane merge of the write data into the pre-write word.
  always_comb begin
    merged = rd_word;
    for (int i = 0; i < 4; i++) begin
      if (cur_be[i]) merged[8*i +: 8] = cur_wdata[8*i +: 8];
    end
  end

  // rst_n gate keeps a held request from committing while reset is asserted.
  assign mem_we = go_resp && cur_wr && rst_n;

`ifdef L2_RESP_ZERO_INIT_EN
  assign clr_we = (state == CLEAR) && rst_n;
`endif

  // Memory array: not reset; written on RESP entry or while clearing.
  always_ff @(posedge clk) begin
`ifdef L2_RESP_ZERO_INIT_EN
    if (clr_we) begin
      mem[clr_idx] <= '0;
    end else if (mem_we) begin
      mem[cur_idx] <= merged;
    end
`else
    if (mem_we) begin
      mem[cur_idx] <= merged;
    end
`endif
  end

  // Sequencing FSM with registered resp/rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RESET_STATE;
      cnt           <= 8'd0;
      op_wr         <= 1'b0;
      idx           <= '0;
      wdata_q       <= '0;
      be_q          <= 4'd0;
      L2cache_resp  <= 1'b0;
      L2cache_rdata <= '0;
`ifdef L2_RESP_ZERO_INIT_EN
      clr_idx       <= '0;
`endif
    end else begin
      L2cache_resp <= 1'b0;
      if (go_resp) begin
        L2cache_rdata <= rd_word;
        L2cache_resp  <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (req) begin
            op_wr   <= L2cache_write;
            idx     <= L2cache_address[ADDR_BITS+1:2];
            wdata_q <= L2cache_wdata;
            be_q    <= L2cache_byte_enable;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= BUSY;
              cnt   <= 8'(LATENCY - 1);
            end
          end
        end
        BUSY: begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) state <= RESP;
        end
        RESP: state <= TURN;
        TURN: state <= IDLE;
`ifdef L2_RESP_ZERO_INIT_EN
        CLEAR: begin
          if (clr_idx == ADDR_BITS'(DEPTH - 1)) begin
            state <= IDLE;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
